// File: rtl/fifo_wr_arbiter.sv
// Purpose : round-robin arbiter granting one of NREQ requesters a burst of up
//           to MAX_BURST beats into a single shared FIFO write port.
// Latency : one IDLE cycle per grant decision; beats then pass combinationally
//           from the granted requester to the FIFO port.
// Backpressure: wfull stalls the burst (ready/winc low, beat count held);
//           the granted requester dropping valid ends the burst.
//
// Ports:
//   wclk, wrst_n   write-domain clock, async active-low reset
//   req_valid      per-requester valid          req_data  packed per-requester data
//   req_ready      one-hot (or zero) accept     wfull     FIFO full flag
//   winc, wdata    FIFO write enable / data
//   gnt_id         current or last granted requester
//   busy           high while a burst is in progress
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                     wclk,
  input  logic                     wrst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DSIZE-1:0]    req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     wfull,
  output logic                     winc,
  output logic [DSIZE-1:0]         wdata,
  output logic [$clog2(NREQ)-1:0]  gnt_id,
  output logic                     busy
);

  localparam int GW = $clog2(NREQ);
  // One extra code point so the counter can sit at MAX_BURST itself.
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [GW-1:0]   r_rr_ptr;
  logic [GW-1:0]   r_gnt_id;
  logic [BW-1:0]   r_beat_cnt;

  logic [GW-1:0]   w_sel;
  logic            w_any;
  logic            w_burst_end;
  logic [GW-1:0]   w_gnt_plus1;

  // Round-robin pick: walk from rr_ptr+NREQ-1 down to rr_ptr so the last hit,
  // i.e. the first valid index at or after rr_ptr, is the one that sticks.
  always_comb begin
    w_sel = r_rr_ptr;
    w_any = |req_valid;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int idx;
      idx = int'(r_rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_valid[idx]) w_sel = GW'(idx);
    end
  end

  assign w_gnt_plus1 = (r_gnt_id == GW'(NREQ - 1)) ? '0 : r_gnt_id + GW'(1);

  // Burst ends on its last beat or as soon as the owner withdraws valid,
  // independent of wfull.
  assign w_burst_end = (winc && (r_beat_cnt == BW'(MAX_BURST - 1)))
                       || !req_valid[r_gnt_id];

  // FSM: state register
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // FSM: next state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_any)       w_next_state = S_BURST;
      S_BURST: if (w_burst_end) w_next_state = S_IDLE;
      default:                  w_next_state = S_IDLE;
    endcase
  end

  // FSM: outputs. Everything is decoded from the state register so an
  // asynchronous reset silences winc/ready/busy without waiting for a clock.
  always_comb begin
    busy      = 1'b0;
    winc      = 1'b0;
    req_ready = '0;
    if (r_state == S_BURST) begin
      busy                = 1'b1;
      req_ready[r_gnt_id] = ~wfull;
      winc                = req_valid[r_gnt_id] & ~wfull;
    end
  end

  assign wdata  = req_data[int'(r_gnt_id)*DSIZE +: DSIZE];
  assign gnt_id = r_gnt_id;

  // Grant, beat counter and round-robin pointer.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_rr_ptr   <= '0;
      r_gnt_id   <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt_id   <= w_sel;
            r_beat_cnt <= '0;
          end
        end
        S_BURST: begin
          if (winc && (r_beat_cnt != BW'(MAX_BURST)))
            r_beat_cnt <= r_beat_cnt + BW'(1);
          if (w_burst_end)
            r_rr_ptr <= w_gnt_plus1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Purpose : randomized + directed bench for fifo_wr_arbiter against a
//           transaction-level model (owner / beats-taken / round-robin pointer).
// Latency : inputs driven 1 time unit after the rising edge, outputs sampled 1 later.
// Backpressure: wfull driven randomly and in directed stall patterns.
module tb_fifo_wr_arbiter;

  localparam int NREQ      = 4;
  localparam int DSIZE     = 8;
  localparam int MAX_BURST = 4;

  logic                    wclk = 1'b0;
  logic                    wrst_n;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*DSIZE-1:0]   req_data;
  logic [NREQ-1:0]         req_ready;
  logic                    wfull;
  logic                    winc;
  logic [DSIZE-1:0]        wdata;
  logic [$clog2(NREQ)-1:0] gnt_id;
  logic                    busy;

  fifo_wr_arbiter #(
    .NREQ      (NREQ),
    .DSIZE     (DSIZE),
    .MAX_BURST (MAX_BURST)
  ) u_dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wfull     (wfull),
    .winc      (winc),
    .wdata     (wdata),
    .gnt_id    (gnt_id),
    .busy      (busy)
  );

  always #5 wclk = ~wclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the port (-1 = nobody), beats already written,
  // where the next search starts, and the last grant for gnt_id.
  int m_owner;
  int m_beats;
  int m_rr;
  int m_gnt;

  // Observations for the directed phases.
  int winc_cnt;
  int grants[$];
  logic prev_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner   = -1;
    m_beats   = 0;
    m_rr      = 0;
    m_gnt     = 0;
    prev_busy = 1'b0;
  endtask

  // Asynchronous reset pulse between edges; outputs must drop at once.
  task automatic pulse_reset();
    wrst_n = 1'b0;
    #1;
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_winc",  32'(winc),      32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_gnt",   32'(gnt_id),    32'd0);
    model_reset();
    wrst_n = 1'b1;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then
  // advance the model by the edge that ends the cycle.
  task automatic cycle(input logic [NREQ-1:0] v, input logic f);
    logic        e_busy;
    logic        e_winc;
    logic [NREQ-1:0] e_ready;
    req_valid = v;
    wfull     = f;
    for (int i = 0; i < NREQ; i++) req_data[i*DSIZE +: DSIZE] = DSIZE'($urandom);
    #1;
    e_busy  = (m_owner >= 0);
    e_winc  = e_busy && v[m_owner] && !f;
    e_ready = (e_busy && !f) ? NREQ'(1 << m_owner) : '0;
    chk("busy",  32'(busy),      32'(e_busy));
    chk("winc",  32'(winc),      32'(e_winc));
    chk("ready", 32'(req_ready), 32'(e_ready));
    chk("gnt_id", 32'(gnt_id),   32'(m_gnt));
    if (e_winc) chk("wdata", 32'(wdata), 32'(req_data[m_owner*DSIZE +: DSIZE]));
    chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
    if (winc) chk("winc_legal", 32'(req_valid[gnt_id] & ~wfull), 32'd1);
    if (winc) winc_cnt++;
    if (busy && !prev_busy) grants.push_back(int'(gnt_id));
    prev_busy = busy;
    // model step
    if (m_owner < 0) begin
      if (v != '0) begin
        for (int k = 0; k < NREQ; k++) begin
          if (m_owner < 0 && v[(m_rr + k) % NREQ]) m_owner = (m_rr + k) % NREQ;
        end
        m_gnt   = m_owner;
        m_beats = 0;
      end
    end else begin
      if (e_winc) m_beats++;
      if ((e_winc && m_beats == MAX_BURST) || !v[m_owner]) begin
        m_rr    = (m_owner + 1) % NREQ;
        m_owner = -1;
      end
    end
    @(posedge wclk);
    #1;
  endtask

  logic [NREQ-1:0] rv;
  logic            rf;

  initial begin
    wrst_n    = 1'b0;
    req_valid = '0;
    req_data  = '0;
    wfull     = 1'b0;
    model_reset();
    #12;
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_winc",  32'(winc),      32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_gnt",   32'(gnt_id),    32'd0);
    wrst_n = 1'b1;

    // Single requester held: 3 bursts of 4 in 15 cycles, always grant 0.
    winc_cnt = 0;
    grants.delete();
    for (int c = 0; c < 15; c++) cycle(4'b0001, 1'b0);
    chk("single_beats",  32'(winc_cnt),      32'd12);
    chk("single_bursts", 32'(grants.size()), 32'd3);
    foreach (grants[i]) chk("single_gnt", 32'(grants[i]), 32'd0);

    // All four valid from reset: grants 0,1,2,3,0 with 4 beats each.
    pulse_reset();
    winc_cnt = 0;
    grants.delete();
    for (int c = 0; c < 25; c++) cycle(4'b1111, 1'b0);
    chk("all_beats",  32'(winc_cnt),      32'd20);
    chk("all_bursts", 32'(grants.size()), 32'd5);
    for (int i = 0; i < 5 && i < grants.size(); i++)
      chk("all_order", 32'(grants[i]), 32'(i % NREQ));

    // Stall inside grant 2: 3 wfull cycles, still exactly 4 beats.
    pulse_reset();
    for (int c = 0; c < 10; c++) cycle(4'b1111, 1'b0);   // bursts for 0 and 1
    winc_cnt = 0;
    cycle(4'b1111, 1'b0);                                 // IDLE, grant 2
    cycle(4'b1111, 1'b0);                                 // beat 1
    for (int c = 0; c < 3; c++) cycle(4'b1111, 1'b1);     // stalled
    for (int c = 0; c < 3; c++) cycle(4'b1111, 1'b0);     // beats 2..4
    chk("stall_beats", 32'(winc_cnt), 32'd4);
    chk("stall_idle",  32'(busy),     32'd0);

    // Requester 1 drops after 2 beats; next winner is lowest valid at/after 2.
    pulse_reset();
    for (int c = 0; c < 5; c++) cycle(4'b0011, 1'b0);     // burst of req 0
    cycle(4'b0011, 1'b0);                                 // grant 1
    cycle(4'b0011, 1'b0);
    cycle(4'b0011, 1'b0);
    cycle(4'b1001, 1'b0);                                 // drop: burst ends
    chk("drop_idle", 32'(busy), 32'd0);
    cycle(4'b1001, 1'b0);                                 // arbitrate from 2
    chk("drop_gnt",  32'(gnt_id), 32'd3);

    // Reset during beat 3 of grant 3, then restart from index 0.
    pulse_reset();
    for (int c = 0; c < 15; c++) cycle(4'b1111, 1'b0);   // bursts 0,1,2
    cycle(4'b1111, 1'b0);                                 // grant 3
    cycle(4'b1111, 1'b0);
    cycle(4'b1111, 1'b0);
    pulse_reset();
    cycle(4'b1111, 1'b0);
    cycle(4'b1111, 1'b0);
    chk("rst_restart_gnt", 32'(gnt_id), 32'd0);

    // Random traffic with sticky valids, random backpressure and resets.
    rv = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(7) == 0) rv[i] = ~rv[i];
      rf = ($urandom_range(3) == 0);
      if ($urandom_range(199) == 0) pulse_reset();
      cycle(rv, rf);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
